// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the single-transaction Wishbone command master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, bus-mode constants, and the response record
// that the master holds stable until the consumer takes it.
package wb_cmd_master_pkg;

    // Bus-mode selector values for g_pipelined.
    localparam int c_WBM_CLASSIC   = 0;
    localparam int c_WBM_PIPELINED = 1;

    // Widest data bus the response record can carry.
    localparam int c_WBM_MAX_DW = 32;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_RESP     = 2'd3
    } t_wbm_state;

    typedef struct packed {
        logic [c_WBM_MAX_DW-1:0] dat;
        logic                    err;
        logic                    timeout;
    } t_wbm_rsp;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-transaction Wishbone master driven by a valid/ready command port.
// Latency: cyc/stb one cycle after command accept; response one cycle after ack/err/timeout.
// Backpressure: one outstanding transaction; cmd_ready_o low until the response is consumed.
//
// Ports:
//   clk_sys_i, rst_i          clock, synchronous active-high reset
//   cmd_*                     command in (valid/ready): we, adr, dat, sel
//   rsp_*                     response out (valid/ready): dat, err, timeout
//   wb_*                      Wishbone initiator side (classic or pipelined)
//   busy_o                    high whenever a command is in flight or its response pending
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int g_addr_width = 32,
    parameter int g_data_width = 32,
    parameter int g_pipelined  = 1,
    parameter int g_timeout    = 255
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_i,

    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [g_addr_width-1:0]   cmd_adr_i,
    input  logic [g_data_width-1:0]   cmd_dat_i,
    input  logic [g_data_width/8-1:0] cmd_sel_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [g_data_width-1:0]   rsp_dat_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,

    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [g_addr_width-1:0]   wb_adr_o,
    output logic [g_data_width-1:0]   wb_dat_o,
    output logic [g_data_width/8-1:0] wb_sel_o,
    input  logic [g_data_width-1:0]   wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i,
    input  logic                      wb_stall_i,

    output logic                      busy_o
);

    // Timeout counter sized from the limit, clamped to 8..16 bits.
    localparam int c_cnt_raw = $clog2(g_timeout + 1);
    localparam int c_cnt_w   = (c_cnt_raw < 8) ? 8 : ((c_cnt_raw > 16) ? 16 : c_cnt_raw);
    // The counter value that, when incremented this cycle, reaches g_timeout.
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(g_timeout - 1);
    localparam bit c_pipe = (g_pipelined != c_WBM_CLASSIC);

    t_wbm_state         state;
    t_wbm_rsp           rsp_q;
    logic [c_cnt_w-1:0] tmo_cnt;
    logic               tmo_hit;
    logic               term;

    // Internal decode only; every output below comes from a register.
    always_comb begin
        tmo_hit = (tmo_cnt == c_limit);
        term    = wb_ack_i | wb_err_i | tmo_hit;
    end

    assign rsp_dat_o     = rsp_q.dat[g_data_width-1:0];
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_q       <= '0;
            tmo_cnt     <= '0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        wb_we_o     <= cmd_we_i;
                        wb_adr_o    <= cmd_adr_i;
                        wb_dat_o    <= cmd_dat_i;
                        wb_sel_o    <= cmd_sel_i;
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        tmo_cnt     <= '0;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end

                S_ISSUE, S_WAIT_ACK: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (term) begin
                        // Priority: err over ack, either over timeout.
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= S_RESP;
                        if (wb_err_i) begin
                            rsp_q.dat     <= '0;
                            rsp_q.err     <= 1'b1;
                            rsp_q.timeout <= 1'b0;
                        end else if (wb_ack_i) begin
                            rsp_q.dat     <= wb_we_o ? '0 : c_WBM_MAX_DW'(wb_dat_i);
                            rsp_q.err     <= 1'b0;
                            rsp_q.timeout <= 1'b0;
                        end else begin
                            rsp_q.dat     <= '0;
                            rsp_q.err     <= 1'b1;
                            rsp_q.timeout <= 1'b1;
                        end
                    end else if (state == S_ISSUE && c_pipe && !wb_stall_i) begin
                        // Slave took the strobe; keep cyc and wait for termination.
                        wb_stb_o <= 1'b0;
                        state    <= S_WAIT_ACK;
                    end
                end

                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
